// File: rtl/sa_pkg.sv
// Shared constants and lane slicing helper for the systolic array skew and unskew stages.
// Lane 0 of a packed row always occupies the most significant bits.
package sa_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int MAX_M  = 8;

    // Rows narrower than MAX_M lanes are right-aligned in the wide argument.
    function automatic logic [ACC_W-1:0] lane(input logic [ACC_W*MAX_M-1:0] row,
                                              input int i,
                                              input int m);
        return row[ACC_W*(m-i)-1 -: ACC_W];
    endfunction

endpackage

// File: rtl/lane_delay.sv
// N-stage register chain with asynchronous active-low reset; N=0 degenerates to a wire.
module lane_delay
    import sa_pkg::*;
#(
    parameter int W = ACC_W,
    parameter int N = 1
)(
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    if (N == 0) begin : g_wire
        logic w_unused_clk_rst;
        assign w_unused_clk_rst = CLK ^ RST_N;
        assign o_q = i_d;
    end else begin : g_chain
        logic [W-1:0] r_stage [N];

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                for (int k = 0; k < N; k++) r_stage[k] <= '0;
            end else begin
                r_stage[0] <= i_d;
                for (int k = 1; k < N; k++) r_stage[k] <= r_stage[k-1];
            end
        end

        assign o_q = r_stage[N-1];
    end

endmodule

// File: rtl/unskew_drain.sv
// Realigns staggered systolic result lanes and drains whole rows through a FIFO with valid/ready.
// Optional DRAIN_STATS_EN adds the mat_count port counting completed matrices.
module unskew_drain
    import sa_pkg::*;
#(
    parameter int M     = 3,
    parameter int W     = ACC_W,
    parameter int DEPTH = 6
)(
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           in_valid,
    input  logic [W*M-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W*M-1:0] out_data,
    output logic           out_last,
    output logic           overflow
`ifdef DRAIN_STATS_EN
    ,
    output logic [15:0]    mat_count
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [RW-1:0] LAST_ROW = RW'(M - 1);

    logic [W*M-1:0] w_aligned;
    logic           w_aligned_valid;

    // Lane i lags lane 0 by i cycles, so it needs M-1-i stages to catch up with lane M-1.
    for (genvar gi = 0; gi < M; gi++) begin : g_lane
        lane_delay #(.W(W), .N(M-1-gi)) u_lane (
            .CLK   (CLK),
            .RST_N (RST_N),
            .i_d   (in_data[W*(M-gi)-1 -: W]),
            .o_q   (w_aligned[W*(M-gi)-1 -: W])
        );
    end

    lane_delay #(.W(1), .N(M-1)) u_valid (
        .CLK   (CLK),
        .RST_N (RST_N),
        .i_d   (in_valid),
        .o_q   (w_aligned_valid)
    );

    logic [W*M-1:0] r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [RW-1:0]  r_row_cnt;
    logic           r_overflow;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && out_ready;
    // A pop frees the head slot on the same edge, so a full FIFO can still accept.
    assign w_push  = w_aligned_valid && (!w_full || w_pop);
    assign w_drop  = w_aligned_valid && w_full && !w_pop;

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign out_last  = out_valid && (r_row_cnt == LAST_ROW);
    assign overflow  = r_overflow;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_aligned;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= nextPtr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= nextPtr(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_row_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) r_row_cnt <= (r_row_cnt == LAST_ROW) ? '0 : r_row_cnt + 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

`ifdef DRAIN_STATS_EN
    logic [15:0] r_mat_count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                r_mat_count <= '0;
        else if (w_pop && out_last) r_mat_count <= r_mat_count + 16'd1;
    end

    assign mat_count = r_mat_count;
`endif

endmodule

// File: tb/tb_unskew_drain.sv
// Directed bench for unskew_drain: skews rows in software, scoreboards the aligned output.
// Exercises DRAIN_STATS_EN checks when that macro is defined for the build.
module tb_unskew_drain;
    import sa_pkg::*;

    localparam int M     = 3;
    localparam int W     = 16;
    localparam int DEPTH = 6;
    localparam int RW    = W * M;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          in_valid;
    logic [RW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic          out_last;
    logic          overflow;
`ifdef DRAIN_STATS_EN
    logic [15:0]   mat_count;
`endif

    unskew_drain #(.M(M), .W(W), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow)
`ifdef DRAIN_STATS_EN
        ,
        .mat_count (mat_count)
`endif
    );

    always #5 CLK = ~CLK;

    logic [RW-1:0] expQ [$];
    logic [RW-1:0] histRow [M];
    logic          histValid [M];
    int            tbRowCnt;
    int            tbMatCount;
    int            popCount;
    int            testsRun    = 0;
    int            testsFailed = 0;
    logic          sampledValid;
    logic          sampledLast;
    logic          sampledOverflow;

    function automatic logic [RW-1:0] mkRow(input logic [15:0] base);
        return {base + 16'd1, base + 16'd2, base + 16'd3};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        expQ.delete();
        tbRowCnt = 0;
        for (int i = 0; i < M; i++) begin
            histRow[i]   = '0;
            histValid[i] = 1'b0;
        end
    endtask

    // One clock cycle: drive skewed lanes, sample outputs mid-cycle, score any handshake.
    task automatic applyStimulus(input logic v, input logic [RW-1:0] row,
                                 input logic rdy, input logic keep);
        logic [ACC_W*MAX_M-1:0] wide;
        logic [RW-1:0]          expRow;
        logic                   expLast;
        for (int i = M - 1; i > 0; i--) begin
            histRow[i]   = histRow[i-1];
            histValid[i] = histValid[i-1];
        end
        histRow[0]   = row;
        histValid[0] = v;
        in_valid     = v;
        out_ready    = rdy;
        for (int i = 0; i < M; i++) begin
            wide          = '0;
            wide[RW-1:0]  = histRow[i];
            in_data[W*(M-i)-1 -: W] = histValid[i] ? lane(wide, i, M) : '0;
        end
        if (v && keep) expQ.push_back(row);

        @(negedge CLK);
        sampledValid    = out_valid;
        sampledLast     = out_last;
        sampledOverflow = overflow;
        if (out_valid && out_ready) begin
            checkOutput("sb_has_row", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) begin
                expRow  = expQ.pop_front();
                expLast = (tbRowCnt == M - 1);
                checkOutput("row_data", 64'(out_data), 64'(expRow));
                checkOutput("row_last", 64'(out_last), 64'(expLast));
                tbRowCnt = expLast ? 0 : tbRowCnt + 1;
                if (expLast) tbMatCount++;
                popCount++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((expQ.size() != 0 || out_valid) && n < budget) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b1);
            n++;
        end
        checkOutput("drain_in_budget", 64'(n < budget), 64'd1);
        checkOutput("drain_empty", 64'(out_valid), 64'd0);
    endtask

    task automatic doReset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        RST_N     = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        resetModel();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbMatCount = 0;
        popCount   = 0;
        resetModel();

        // Reset state
        RST_N     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data",  64'(out_data),  64'd0);
        checkOutput("rst_out_last",  64'(out_last),  64'd0);
        checkOutput("rst_overflow",  64'(overflow),  64'd0);
`ifdef DRAIN_STATS_EN
        checkOutput("rst_mat_count", 64'(mat_count), 64'd0);
`endif
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Three back-to-back rows: valid on cycles 3..5, last only on cycle 5
        for (int k = 0; k < 7; k++) begin
            applyStimulus(k < 3, mkRow(16'(k * 16)), 1'b1, 1'b1);
            checkOutput("lat_valid", 64'(sampledValid), 64'(k >= 3 && k <= 5));
            checkOutput("lat_last",  64'(sampledLast),  64'(k == 5));
        end

        // Seven rows into a stalled FIFO: six held, seventh dropped
        doReset();
        for (int k = 0; k < 7; k++)
            applyStimulus(1'b1, mkRow(16'(16'h0100 + k * 16)), 1'b0, k < 6);
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("ovf_set",      64'(sampledOverflow), 64'd1);
        checkOutput("ovf_held_vld", 64'(sampledValid),    64'd1);
        popCount = 0;
        drain(20);
        checkOutput("ovf_pop_count", 64'(popCount), 64'd6);
        checkOutput("ovf_sticky",    64'(overflow), 64'd1);

        // Full FIFO with push and pop on the same edge
        doReset();
        for (int k = 0; k < 9; k++)
            applyStimulus(k < 7, mkRow(16'(16'h0200 + k * 16)), k == 8, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("full_pp_ovf", 64'(sampledOverflow), 64'd0);
        checkOutput("full_pp_vld", 64'(sampledValid),    64'd1);
        popCount = 0;
        drain(20);
        checkOutput("full_pp_count", 64'(popCount), 64'd6);
        checkOutput("full_pp_ovf_end", 64'(overflow), 64'd0);

        // Reset pulse mid-cycle with rows buffered
        doReset();
        applyStimulus(1'b1, mkRow(16'h0300), 1'b0, 1'b1);
        applyStimulus(1'b1, mkRow(16'h0310), 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("midrst_pre_vld", 64'(sampledValid), 64'd1);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("midrst_vld",  64'(out_valid), 64'd0);
        checkOutput("midrst_data", 64'(out_data),  64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        resetModel();
        @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, mkRow(16'(16'h0400 + k * 16)), 1'b1, 1'b1);
        drain(20);

`ifdef DRAIN_STATS_EN
        // Matrix counter: two matrices, then wrap from FFFF
        doReset();
        checkOutput("stats_rst", 64'(mat_count), 64'd0);
        for (int k = 0; k < 6; k++)
            applyStimulus(1'b1, mkRow(16'(16'h0500 + k * 16)), 1'b1, 1'b1);
        drain(20);
        checkOutput("stats_two", 64'(mat_count), 64'd2);
        force dut.r_mat_count = 16'hFFFF;
        #1;
        release dut.r_mat_count;
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, mkRow(16'(16'h0600 + k * 16)), 1'b1, 1'b1);
        drain(20);
        checkOutput("stats_wrap", 64'(mat_count), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
